// File: rtl/led_blink_slot_pkg.sv
// Shared types and field positions for the LED blink slot.
// Channel register: [15:0] interval in ms, [17:16] mode, LED state read back in bit 31.
package led_blink_slot_pkg;

  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned INTERVAL_W   = 16;
  localparam int unsigned INTERVAL_LSB = 0;
  localparam int unsigned MODE_W       = 2;
  localparam int unsigned MODE_LSB     = 16;
  localparam int unsigned CFG_W        = 18;
  localparam int unsigned LED_RD_BIT   = 31;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e                 mode;
    logic [INTERVAL_W-1:0] interval;
  } chan_cfg_t;

  // Read-back word: config fields in place, LED state in the top bit, reserved bits 0.
  function automatic logic [DATA_W-1:0] rd_word(chan_cfg_t cfg, logic led);
    logic [DATA_W-1:0] w;
    w                              = '0;
    w[INTERVAL_LSB +: INTERVAL_W]  = cfg.interval;
    w[MODE_LSB +: MODE_W]          = cfg.mode;
    w[LED_RD_BIT]                  = led;
    return w;
  endfunction

endpackage

// File: rtl/led_blink_slot_if.sv
// Register slot bus between a host (master) and the LED blink slot (slave).
interface led_blink_slot_if;
  import led_blink_slot_pkg::*;

  logic              cs;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);

endinterface

// File: rtl/led_blink_slot_chan.sv
// One LED channel: config register, ms counter, LED state and ONESHOT self-clear.
module led_chan
  import led_blink_slot_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  logic      wr_en,
  input  chan_cfg_t wr_cfg,
  output chan_cfg_t cfg,
  output logic      led
);

  chan_cfg_t             cfg_q, cfg_d;
  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic                  led_q, led_d;
  logic                  last_c;
  logic                  zero_iv_c;

  assign zero_iv_c = (cfg_q.interval == '0);
  assign last_c    = (cnt_q == cfg_q.interval - INTERVAL_W'(1));

  // A write wins over any tick on the same edge; counter never passes interval-1.
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    led_d = led_q;
    if (wr_en) begin
      cfg_d = wr_cfg;
      cnt_d = '0;
      led_d = (wr_cfg.mode == MODE_ONESHOT) && (wr_cfg.interval != '0);
    end else begin
      case (cfg_q.mode)
        MODE_OFF: begin
          cnt_d = '0;
          led_d = 1'b0;
        end
        MODE_ON: begin
          cnt_d = '0;
          led_d = 1'b1;
        end
        MODE_BLINK: begin
          if (zero_iv_c) begin
            cnt_d = '0;
            led_d = 1'b0;
          end else if (tick) begin
            if (last_c) begin
              cnt_d = '0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + INTERVAL_W'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          if (zero_iv_c) begin
            cnt_d = '0;
            led_d = 1'b0;
          end else if (tick) begin
            if (last_c) begin
              cnt_d      = '0;
              led_d      = 1'b0;
              cfg_d.mode = MODE_OFF;
            end else begin
              cnt_d = cnt_q + INTERVAL_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign cfg = cfg_q;
  assign led = led_q;

endmodule

// File: rtl/led_blink_slot.sv
// LED blink slot: shared 1 ms prescaler, address decode and N_CH blink/oneshot channels.
module led_blink_slot
  import led_blink_slot_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned W        = 16,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_blink_slot_if.slave      bus,
  output logic [W-1:0]         dout
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_c;
  chan_cfg_t        wr_cfg_c;
  chan_cfg_t        cfg_c [N_CH];
  logic [N_CH-1:0]  wr_en_c;
  logic [N_CH-1:0]  led_c;
  logic             unused_c;

  // Tick fires on the edge where the prescaler wraps back to 0.
  assign tick_c = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  always_comb begin
    wr_cfg_c.interval = bus.wr_data[INTERVAL_LSB +: INTERVAL_W];
    wr_cfg_c.mode     = mode_e'(bus.wr_data[MODE_LSB +: MODE_W]);
  end

  assign unused_c = ^{bus.read, bus.wr_data[DATA_W-1:CFG_W]};

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign wr_en_c[i] = bus.cs && bus.write && (bus.addr == ADDR_W'(i));

    led_chan u_chan (
      .clk    (clk),
      .rst_n  (reset_n),
      .tick   (tick_c),
      .wr_en  (wr_en_c[i]),
      .wr_cfg (wr_cfg_c),
      .cfg    (cfg_c[i]),
      .led    (led_c[i])
    );
  end

  // Out-of-range addresses read as 0.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.addr == ADDR_W'(i)) begin
        bus.rd_data = rd_word(cfg_c[i], led_c[i]);
      end
    end
  end

  // Channel i lands on dout[W-1-i]; remaining bits stay 0.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N_CH; i++) begin
      dout[W-1-i] = led_c[i];
    end
  end

endmodule

// File: tb/tb_led_blink_slot.sv
// Bench for led_blink_slot: arithmetic reference model checked every cycle plus literal expectations.
module tb_led_blink_slot;
  import led_blink_slot_pkg::*;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 16;
  localparam int          TD   = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] dout;

  led_blink_slot_if bus();

  led_blink_slot #(.N_CH(N_CH), .W(W), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: edge count since reset and, per channel, the edge and config of the last write.
  int          e;
  bit          vld  [N_CH];
  int          wr_e [N_CH];
  logic [1:0]  md   [N_CH];
  logic [15:0] iv   [N_CH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e <= 0;
      for (int i = 0; i < N_CH; i++) vld[i] <= 1'b0;
    end else begin
      e <= e + 1;
      for (int i = 0; i < N_CH; i++) begin
        if (bus.cs && bus.write && bus.addr == 5'(i)) begin
          vld[i]  <= 1'b1;
          wr_e[i] <= e + 1;
          md[i]   <= bus.wr_data[17:16];
          iv[i]   <= bus.wr_data[15:0];
        end
      end
    end
  end

  // Ticks counted strictly after the write edge: ticks land on edges that are multiples of TD.
  function automatic int ticks_since(int ch);
    return e / TD - wr_e[ch] / TD;
  endfunction

  function automatic bit exp_led(int ch);
    int k;
    int n;
    if (!reset_n || !vld[ch]) return 1'b0;
    k = ticks_since(ch);
    n = int'(iv[ch]);
    case (md[ch])
      2'd0:    return 1'b0;
      2'd1:    return e > wr_e[ch];
      2'd2:    return (n != 0) && (((k / (n == 0 ? 1 : n)) % 2) == 1);
      default: return (n != 0) && (k < n);
    endcase
  endfunction

  function automatic logic [1:0] exp_mode(int ch);
    if (md[ch] == 2'd3 && iv[ch] != 16'd0 && ticks_since(ch) >= int'(iv[ch])) return 2'd0;
    return md[ch];
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    logic [31:0] r;
    r = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (a == 5'(ch) && reset_n && vld[ch]) begin
        r[15:0]  = iv[ch];
        r[17:16] = exp_mode(ch);
        r[31]    = exp_led(ch);
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] exp_dout();
    logic [W-1:0] r;
    r = '0;
    for (int ch = 0; ch < N_CH; ch++) r[W-1-ch] = exp_led(ch);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    chk("dout_model", 32'(dout), 32'(exp_dout()));
    chk("rd_model", bus.rd_data, exp_rd(bus.addr));
  end

  task automatic rd_lit(input string nm, input int a, input logic [31:0] exp);
    bus.addr = 5'(a);
    #1;
    chk(nm, bus.rd_data, exp);
  endtask

  task automatic drive_write(input int a, input logic [31:0] d);
    bus.cs      = 1'b1;
    bus.write   = 1'b1;
    bus.read    = 1'b0;
    bus.addr    = 5'(a);
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.cs    = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    @(posedge clk);
    #1;
    drive_write(a, d);
  endtask

  // Lands the write on an edge that also carries a prescaler tick.
  task automatic do_write_tick(input int a, input logic [31:0] d);
    @(posedge clk);
    #1;
    while (((e + 1) % TD) != 0) begin
      @(posedge clk);
      #1;
    end
    drive_write(a, d);
  endtask

  task automatic wait_bit(input int b, input logic val, input int limit, output int n);
    n = 0;
    while (dout[b] !== val && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    reset_n     = 1'b0;
    bus.cs      = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    #23 reset_n = 1'b1;

    @(posedge clk);
    #1;
    chk("reset_dout", 32'(dout), 32'h0);
    for (int a = 0; a < 4; a++) rd_lit("reset_rd", a, 32'h0);

    // BLINK, interval 3 ms
    do_write(0, 32'h0002_0003);
    rd_lit("blink_rd_start", 0, 32'h0002_0003);
    wait_bit(15, 1'b1, 40, n);
    rd_lit("blink_rd_on", 0, 32'h8002_0003);
    wait_bit(15, 1'b0, 40, n);
    chk("blink_period_fall", 32'(n), 32'd12);
    rd_lit("blink_rd_off", 0, 32'h0002_0003);
    wait_bit(15, 1'b1, 40, n);
    chk("blink_period_rise", 32'(n), 32'd12);

    // ONESHOT, interval 5 ms
    do_write_tick(1, 32'h0003_0005);
    chk("oneshot_on", 32'(dout[14]), 32'd1);
    rd_lit("oneshot_rd_on", 1, 32'h8003_0005);
    wait_bit(14, 1'b0, 40, n);
    chk("oneshot_len", 32'(n), 32'd20);
    rd_lit("oneshot_rd_done", 1, 32'h0000_0005);

    // ON, then BLINK with zero interval
    do_write(2, 32'h0001_0000);
    @(posedge clk);
    #1;
    chk("on_led", 32'(dout[13]), 32'd1);
    rd_lit("on_rd", 2, 32'h8001_0000);
    do_write(3, 32'h0002_0000);
    repeat (40) @(posedge clk);
    #1;
    chk("zero_iv_led", 32'(dout[12]), 32'd0);
    rd_lit("zero_iv_rd", 3, 32'h0002_0000);

    // Out-of-range write, then write colliding with a tick
    do_write(7, 32'hDEAD_BEEF);
    rd_lit("oor_rd", 7, 32'h0);
    do_write_tick(0, 32'h0002_0003);
    wait_bit(15, 1'b1, 40, n);
    chk("collide_first_toggle", 32'(n), 32'd12);

    // Reserved bits are dropped
    do_write(0, 32'hFFFF_FFFF);
    rd_lit("reserved_rd", 0, 32'h8003_FFFF);
    chk("reserved_low_dout", 32'(dout[11:0]), 32'h0);

    // Reset mid-operation
    do_write(2, 32'h0002_0001);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("reset_mid_dout", 32'(dout), 32'h0);
    for (int a = 0; a < 4; a++) rd_lit("reset_mid_rd", a, 32'h0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd_lit("reset_rel_rd", a, 32'h0);
    chk("reset_rel_dout", 32'(dout), 32'h0);

    // Randomized traffic against the model
    repeat (1500) begin
      int r;
      logic [31:0] d;
      @(posedge clk);
      #1;
      r = $urandom_range(0, 9);
      d = $urandom;
      d[15:0] = 16'($urandom_range(0, 4));
      bus.write   = (r < 3);
      bus.cs      = (r < 3) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
      bus.read    = !bus.write;
      bus.addr    = 5'($urandom_range(0, 8));
      bus.wr_data = d;
    end
    @(posedge clk);
    #1;
    bus.cs    = 1'b0;
    bus.write = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_blink_slot.md
LED_BLINK_SLOT -- requirements
Module: led_blink_slot

Interface
REQ-001 Parameter N_CH, default 4, number of independent LED channels (1..16, N_CH <= W).
REQ-002 Parameter W, default 16, width of dout.
REQ-003 Parameter TICK_DIV, default 100000, clk cycles per 1 ms tick (>= 2).
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cs  input  1  slot select.
REQ-007 read  input  1  read strobe (informational; reads are side-effect free).
REQ-008 write  input  1  write strobe, qualified by cs.
REQ-009 addr  input  5  register address; channel i at addr i.
REQ-010 wr_data  input  32  write data.
REQ-011 rd_data  output  32  read data, combinational from addr.
REQ-012 dout  output  W  LED outputs.

Function
REQ-013 Channel register layout SHALL be: [15:0] interval in ms, [17:16] mode, all other bits reserved (written ignored, read 0).
REQ-014 Modes SHALL be: 00 OFF (LED 0), 01 ON (LED 1), 10 BLINK (toggle every interval ms), 11 ONESHOT (LED 1 for interval ms, then 0 and mode self-clears to OFF).
REQ-015 cs && write with addr < N_CH SHALL update that channel's register on the next clk edge; addr >= N_CH SHALL be ignored.
REQ-016 A write to a channel SHALL also clear that channel's ms counter and LED state in the same edge, except that ONESHOT with interval != 0 SHALL set the LED to 1.
REQ-017 A shared prescaler SHALL count 0..TICK_DIV-1 and assert a one-cycle tick when it wraps to 0; it is never cleared by writes.
REQ-018 In BLINK, on each tick the channel counter SHALL increment; when it reaches interval-1 the LED SHALL toggle and the counter SHALL return to 0 in the same edge.
REQ-019 In ONESHOT, when the counter reaches interval-1 on a tick, LED SHALL go 0, counter 0, mode OFF.
REQ-020 BLINK or ONESHOT with interval 0 SHALL hold LED 0 and counter 0.
REQ-021 OFF and ON SHALL hold the counter at 0; the LED SHALL follow mode one cycle after the write.
REQ-022 A write coinciding with a tick SHALL take priority; that tick is not counted for the written channel.
REQ-023 Channel i SHALL drive dout[W-1-i]; dout bits not driven by a channel SHALL be 0.
REQ-024 rd_data SHALL return, for addr < N_CH, the channel register in [17:0] and current LED state in bit 31; for addr >= N_CH, 0. Returned mode reflects ONESHOT self-clear.
REQ-025 Counters SHALL be 16 bits and SHALL never wrap, since counter <= interval-1 always holds.

Reset
REQ-026 While reset_n = 0, all channel registers, counters, LED states and the prescaler SHALL be 0 immediately, regardless of clk.
REQ-027 After reset, dout SHALL be 0 and rd_data for any valid channel SHALL be 0.
REQ-028 Reset asserted mid-blink or mid-oneshot SHALL abort it; no state survives reset.

Structure
REQ-029 A shared package SHALL hold the 2-bit mode enum (MODE_OFF, MODE_ON, MODE_BLINK, MODE_ONESHOT), field bit positions, and the LED-state read bit index (31).
REQ-030 Per-channel logic (register, counter, LED, ONESHOT self-clear) SHALL be one sub-module, led_chan, instantiated N_CH times via generate; the prescaler and address decode stay in the top.
REQ-031 Implementation SHALL contain no latches; all combinational decode is fully assigned on every path.

Verification (bench uses TICK_DIV=4, N_CH=4, W=16)
REQ-032 Reset: reset_n low mid-operation -> dout=0 immediately; after release rd_data addr 0..3 = 0.
REQ-033 BLINK: write addr 0 = 0x0002_0003 -> dout[15] toggles every 12 clk (3 ticks); rd_data addr 0 = 0x0002_0003 with bit 31 tracking dout[15].
REQ-034 ONESHOT: write addr 1 = 0x0003_0005 -> dout[14]=1 next cycle, falls after 5 ticks (20 clk), rd_data addr 1 then = 0x0000_0005.
REQ-035 ON/OFF and zero interval: write addr 2 = 0x0001_0000 -> dout[13]=1 next cycle; write addr 3 = 0x0002_0000 -> dout[12] stays 0 indefinitely.
REQ-036 Out-of-range and collision: write addr 7 -> no state change, rd_data addr 7 = 0; write addr 0 on a tick cycle -> first toggle exactly interval full ticks later.
REQ-037 Reserved bits: write addr 0 = 0xFFFF_FFFF -> rd_data addr 0 = 0x0003_FFFF plus bit 31 = current LED; dout[11:0] remain 0.
